// File: rtl/pipe_float32_to_fixed_point_pkg.sv
// rtl/pipe_float32_to_fixed_point_pkg.sv - shared types, widths and helpers for the float32 to fixed-point pipe
package fxp_pkg;

  // Widest aligned magnitude is sig << 63 (87 bits) plus one rounding carry.
  localparam int MAG_W = 88;

  typedef enum logic [1:0] {TRUNC = 2'd0, HALF_AWAY = 2'd1, HALF_EVEN = 2'd2} rmode_t;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fclass_t;

  typedef struct packed {
    logic        sign;
    fclass_t     fclass;
    logic [7:0]  expo;
    logic [22:0] man;
  } s1_t;

  typedef struct packed {
    logic             sign;
    fclass_t          fclass;
    logic             big;
    logic [MAG_W-1:0] mag;
  } s2_t;

  function automatic logic [63:0] fix_max(input int woi, input int wof);
    return (64'd1 << (woi + wof - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] fix_min(input int woi, input int wof);
    return 64'd1 << (woi + wof - 1);
  endfunction

  function automatic s1_t unpack_f32(input logic [31:0] f);
    s1_t s;
    s.sign = f[31];
    s.expo = f[30:23];
    s.man  = f[22:0];
    if (f[30:23] == 8'hFF)      s.fclass = (f[22:0] != 23'd0) ? NAN : INF;
    else if (f[30:23] == 8'h00) s.fclass = ZERO;
    else                        s.fclass = NORM;
    return s;
  endfunction

endpackage

// File: rtl/pipe_float32_to_fixed_point_if.sv
// rtl/pipe_float32_to_fixed_point_if.sv - input float stream and output fixed-point stream of the converter
interface pipe_float32_to_fixed_point_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_float;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_fix;
  logic         out_upflow;
  logic         out_downflow;
  logic         out_nan;

  modport slave (
    input  in_valid, in_float, out_ready,
    output in_ready, out_valid, out_fix, out_upflow, out_downflow, out_nan
  );

  modport master (
    output in_valid, in_float, out_ready,
    input  in_ready, out_valid, out_fix, out_upflow, out_downflow, out_nan
  );
endinterface

// File: rtl/pipe_float32_to_fixed_point_mag_round.sv
// rtl/pipe_float32_to_fixed_point_mag_round.sv - combinational align of a normal float magnitude to WOF bits and round
module comb_f32_mag_round
  import fxp_pkg::*;
#(
  parameter int WOF   = 8,
  parameter int RMODE = 1
) (
  input  logic [7:0]       expo,
  input  logic [22:0]      man,
  output logic [MAG_W-1:0] mag,
  output logic             big
);
  logic [23:0]        sig;
  logic signed [10:0] sh;
  logic [5:0]         rs;
  logic [48:0]        t;
  logic [MAG_W-1:0]   base;
  logic               guard, sticky, inc;

  always_comb begin
    sig    = {1'b1, man};
    sh     = $signed({3'b000, expo}) - 11'sd150 + 11'(WOF);
    big    = 1'b0;
    guard  = 1'b0;
    sticky = 1'b0;
    base   = '0;
    rs     = '0;
    t      = '0;
    if (sh >= 0) begin
      // Shifts of 64+ leave the low 64 bits zero and always overflow.
      if (sh > 63) big = 1'b1;
      else         base = MAG_W'(sig) << sh[5:0];
    end else begin
      // Beyond 26 right shifts the result is always mag=0, guard=0, sticky=1.
      rs     = (sh < -26) ? 6'd26 : 6'(-sh);
      t      = {sig, 25'b0} >> rs;
      base   = MAG_W'(t[48:25]);
      guard  = t[24];
      sticky = |t[23:0];
    end
    case (rmode_t'(RMODE))
      HALF_AWAY: inc = guard;
      HALF_EVEN: inc = guard & (sticky | base[0]);
      default:   inc = 1'b0;
    endcase
    mag = base + MAG_W'(inc);
  end
endmodule

// File: rtl/pipe_float32_to_fixed_point.sv
// rtl/pipe_float32_to_fixed_point.sv - 3-stage float32 to signed fixed-point converter with stall and overflow counters
module pipe_float32_to_fixed_point
  import fxp_pkg::*;
#(
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROOF  = 1,
  parameter int RMODE = 1,
  parameter int CNTW  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  pipe_float32_to_fixed_point_if.slave io,
  input  logic                         cnt_clr,
  output logic [CNTW-1:0]              cnt_upflow,
  output logic [CNTW-1:0]              cnt_downflow
);
  localparam int W = WOI + WOF;
  localparam logic [W-1:0]     SAT_POS = W'(fix_max(WOI, WOF));
  localparam logic [W-1:0]     SAT_NEG = W'(fix_min(WOI, WOF));
  localparam logic [MAG_W-1:0] LIM_POS = MAG_W'(fix_max(WOI, WOF));
  localparam logic [MAG_W-1:0] LIM_NEG = MAG_W'(fix_min(WOI, WOF));

  logic             en, hs;
  logic             s1_v, s2_v;
  s1_t              s1;
  s2_t              s2;
  logic [MAG_W-1:0] rnd_mag, neg_mag;
  logic             rnd_big;
  logic [W-1:0]     fix_d;
  logic             up_d, dn_d, nan_d, ovf;

  assign en          = !io.out_valid || io.out_ready;
  assign io.in_ready = en;
  assign hs          = io.out_valid && io.out_ready;

  comb_f32_mag_round #(.WOF(WOF), .RMODE(RMODE)) u_round (
    .expo (s1.expo),
    .man  (s1.man),
    .mag  (rnd_mag),
    .big  (rnd_big)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s1   <= '0;
      s2_v <= 1'b0;
      s2   <= '0;
    end else if (en) begin
      s1_v <= io.in_valid;
      s1   <= unpack_f32(io.in_float);
      s2_v <= s1_v;
      s2   <= '{sign: s1.sign, fclass: s1.fclass, big: rnd_big, mag: rnd_mag};
    end
  end

  // Infinity has no finite wrapped value, so it takes the range limit in both modes.
  always_comb begin
    neg_mag = -s2.mag;
    fix_d   = '0;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    nan_d   = 1'b0;
    ovf     = 1'b0;
    case (s2.fclass)
      NAN: nan_d = 1'b1;
      INF: begin
        up_d  = !s2.sign;
        dn_d  = s2.sign;
        fix_d = s2.sign ? SAT_NEG : SAT_POS;
      end
      NORM: begin
        if (s2.sign) begin
          ovf   = s2.big || (s2.mag > LIM_NEG);
          dn_d  = ovf;
          fix_d = (ovf && ROOF != 0) ? SAT_NEG : neg_mag[W-1:0];
        end else begin
          ovf   = s2.big || (s2.mag > LIM_POS);
          up_d  = ovf;
          fix_d = (ovf && ROOF != 0) ? SAT_POS : s2.mag[W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io.out_valid    <= 1'b0;
      io.out_fix      <= '0;
      io.out_upflow   <= 1'b0;
      io.out_downflow <= 1'b0;
      io.out_nan      <= 1'b0;
    end else if (en) begin
      io.out_valid    <= s2_v;
      io.out_fix      <= fix_d;
      io.out_upflow   <= up_d;
      io.out_downflow <= dn_d;
      io.out_nan      <= nan_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_upflow   <= '0;
      cnt_downflow <= '0;
    end else begin
      if (hs && io.out_upflow && cnt_upflow != '1)     cnt_upflow   <= cnt_upflow + CNTW'(1);
      if (hs && io.out_downflow && cnt_downflow != '1) cnt_downflow <= cnt_downflow + CNTW'(1);
    end
  end
endmodule

// File: tb/tb_pipe_float32_to_fixed_point.sv
// tb/tb_pipe_float32_to_fixed_point.sv - self-checking bench for pipe_float32_to_fixed_point over several configurations
module tb_pipe_float32_to_fixed_point;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        cnt_clr = 1'b0;
  logic [31:0] in_float = 32'h0;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  pipe_float32_to_fixed_point_if #(.W(16)) if_a ();
  pipe_float32_to_fixed_point_if #(.W(16)) if_t0 ();
  pipe_float32_to_fixed_point_if #(.W(16)) if_t1 ();
  pipe_float32_to_fixed_point_if #(.W(16)) if_t2 ();
  pipe_float32_to_fixed_point_if #(.W(16)) if_w ();

  assign if_a.in_valid  = in_valid;  assign if_a.in_float  = in_float;  assign if_a.out_ready  = out_ready;
  assign if_t0.in_valid = in_valid;  assign if_t0.in_float = in_float;  assign if_t0.out_ready = out_ready;
  assign if_t1.in_valid = in_valid;  assign if_t1.in_float = in_float;  assign if_t1.out_ready = out_ready;
  assign if_t2.in_valid = in_valid;  assign if_t2.in_float = in_float;  assign if_t2.out_ready = out_ready;
  assign if_w.in_valid  = in_valid;  assign if_w.in_float  = in_float;  assign if_w.out_ready  = out_ready;

  logic [3:0] cu_a, cd_a, cu_t0, cd_t0, cu_t1, cd_t1, cu_t2, cd_t2, cu_w, cd_w;
  logic [18:0] res_a, res_t0, res_t1, res_t2, res_w;

  assign res_a  = {if_a.out_nan,  if_a.out_downflow,  if_a.out_upflow,  if_a.out_fix};
  assign res_t0 = {if_t0.out_nan, if_t0.out_downflow, if_t0.out_upflow, if_t0.out_fix};
  assign res_t1 = {if_t1.out_nan, if_t1.out_downflow, if_t1.out_upflow, if_t1.out_fix};
  assign res_t2 = {if_t2.out_nan, if_t2.out_downflow, if_t2.out_upflow, if_t2.out_fix};
  assign res_w  = {if_w.out_nan,  if_w.out_downflow,  if_w.out_upflow,  if_w.out_fix};

  pipe_float32_to_fixed_point #(.WOI(8), .WOF(8), .ROOF(1), .RMODE(1), .CNTW(4)) dut_a (
    .clk(clk), .rst(rst), .io(if_a), .cnt_clr(cnt_clr), .cnt_upflow(cu_a), .cnt_downflow(cd_a));
  pipe_float32_to_fixed_point #(.WOI(16), .WOF(0), .ROOF(1), .RMODE(0), .CNTW(4)) dut_t0 (
    .clk(clk), .rst(rst), .io(if_t0), .cnt_clr(cnt_clr), .cnt_upflow(cu_t0), .cnt_downflow(cd_t0));
  pipe_float32_to_fixed_point #(.WOI(16), .WOF(0), .ROOF(1), .RMODE(1), .CNTW(4)) dut_t1 (
    .clk(clk), .rst(rst), .io(if_t1), .cnt_clr(cnt_clr), .cnt_upflow(cu_t1), .cnt_downflow(cd_t1));
  pipe_float32_to_fixed_point #(.WOI(16), .WOF(0), .ROOF(1), .RMODE(2), .CNTW(4)) dut_t2 (
    .clk(clk), .rst(rst), .io(if_t2), .cnt_clr(cnt_clr), .cnt_upflow(cu_t2), .cnt_downflow(cd_t2));
  pipe_float32_to_fixed_point #(.WOI(8), .WOF(8), .ROOF(0), .RMODE(1), .CNTW(4)) dut_w (
    .clk(clk), .rst(rst), .io(if_w), .cnt_clr(cnt_clr), .cnt_upflow(cu_w), .cnt_downflow(cd_w));

  // Reference: real-valued conversion; result packed as {nan, downflow, upflow, fix[15:0]}.
  function automatic logic [18:0] ref_conv(input logic [31:0] f, input int woi, input int wof,
                                           input int roof, input int rmode);
    int  w  = woi + wof;
    int  e  = int'(f[30:23]);
    bit  s  = f[31];
    real two_w = 2.0 ** w;
    real v, fl, fr, m, r;
    logic [15:0] smax, smin, fix;
    bit up, dn;
    smax = 16'((1 << (w - 1)) - 1);
    smin = 16'(1 << (w - 1));
    if (e == 255 && f[22:0] != 23'd0) return {3'b100, 16'h0000};
    if (e == 255) return s ? {3'b010, smin} : {3'b001, smax};
    if (e == 0) return 19'h0;
    v  = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127 + wof));
    fl = $floor(v);
    fr = v - fl;
    m  = fl;
    if (rmode == 1 && fr >= 0.5) m = fl + 1.0;
    if (rmode == 2 && (fr > 0.5 || (fr == 0.5 && (fl - 2.0 * $floor(fl / 2.0)) == 1.0))) m = fl + 1.0;
    up = !s && (m > (2.0 ** (w - 1)) - 1.0);
    dn = s && (m > (2.0 ** (w - 1)));
    if (roof != 0 && up)      fix = smax;
    else if (roof != 0 && dn) fix = smin;
    else begin
      r = m - two_w * $floor(m / two_w);
      if (s && r != 0.0) r = two_w - r;
      fix = 16'(int'(r));
    end
    return {1'b0, dn, up, fix};
  endfunction

  function automatic logic [31:0] rand_float();
    int k = $urandom_range(0, 15);
    logic [31:0] f;
    f = $urandom;
    if (k == 0)      f[30:23] = 8'hFF;
    else if (k == 1) begin f[30:23] = 8'hFF; f[22] = 1'b1; end
    else if (k == 2) f[30:23] = 8'h00;
    else             f[30:23] = 8'($urandom_range(110, 145));
    return f;
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One isolated conversion; returns the number of negedges after acceptance until out_valid.
  task automatic convert(input logic [31:0] f, output int lat);
    @(posedge clk); #1;
    in_valid = 1'b1; in_float = f; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!if_a.out_valid && lat < 8);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_a.out_valid); end
    checks++; if (res_a !== 19'h0) begin errors++; $display("FAIL reset_fields got=%h exp=00000", res_a); end
    checks++; if ({cu_a, cd_a} !== 8'h00) begin errors++; $display("FAIL reset_counters got=%h exp=00", {cu_a, cd_a}); end
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", if_a.in_ready); end
  endtask

  task automatic test_basic();
    int lat;
    convert(32'h3FC00000, lat);
    checks++; if (lat !== 3 || if_a.out_valid !== 1'b1) begin errors++; $display("FAIL latency got=%0d exp=3", lat); end
    checks++; if (res_a !== {3'b000, 16'h0180}) begin errors++; $display("FAIL basic_1p5 got=%h exp=%h", res_a, {3'b000, 16'h0180}); end
    convert(32'hC2FF0000, lat);
    checks++; if (res_a !== {3'b000, 16'h8080}) begin errors++; $display("FAIL basic_m127p5 got=%h exp=%h", res_a, {3'b000, 16'h8080}); end
  endtask

  task automatic test_rounding();
    logic [31:0] vin [3] = '{32'h40200000, 32'hC0200000, 32'h40600000};
    logic [15:0] e0 [3] = '{16'h0002, 16'hFFFE, 16'h0003};
    logic [15:0] e1 [3] = '{16'h0003, 16'hFFFD, 16'h0004};
    logic [15:0] e2 [3] = '{16'h0002, 16'hFFFE, 16'h0004};
    int lat;
    for (int i = 0; i < 3; i++) begin
      convert(vin[i], lat);
      checks++; if (res_t0 !== {3'b000, e0[i]}) begin errors++; $display("FAIL round_trunc in=%h got=%h exp=%h", vin[i], res_t0, {3'b000, e0[i]}); end
      checks++; if (res_t1 !== {3'b000, e1[i]}) begin errors++; $display("FAIL round_away in=%h got=%h exp=%h", vin[i], res_t1, {3'b000, e1[i]}); end
      checks++; if (res_t2 !== {3'b000, e2[i]}) begin errors++; $display("FAIL round_even in=%h got=%h exp=%h", vin[i], res_t2, {3'b000, e2[i]}); end
    end
  endtask

  task automatic test_limits();
    logic [31:0] vin  [6] = '{32'hC3000000, 32'h43000000, 32'h42FFFFFF, 32'hFF800000, 32'h7FC00000, 32'h00000001};
    logic [18:0] vexp [6] = '{{3'b000, 16'h8000}, {3'b001, 16'h7FFF}, {3'b001, 16'h7FFF},
                              {3'b010, 16'h8000}, {3'b100, 16'h0000}, {3'b000, 16'h0000}};
    int lat;
    for (int i = 0; i < 6; i++) begin
      convert(vin[i], lat);
      checks++; if (res_a !== vexp[i]) begin errors++; $display("FAIL limit in=%h got=%h exp=%h", vin[i], res_a, vexp[i]); end
      if (i == 1) begin
        checks++; if (res_w !== {3'b001, 16'h8000}) begin errors++; $display("FAIL wrap_128 got=%h exp=%h", res_w, {3'b001, 16'h8000}); end
      end
    end
  endtask

  task automatic test_random_model();
    logic [31:0] f;
    logic [18:0] e;
    int lat;
    for (int i = 0; i < 30; i++) begin
      f = rand_float();
      convert(f, lat);
      e = ref_conv(f, 8, 8, 1, 1);
      checks++; if (res_a !== e) begin errors++; $display("FAIL rand_a in=%h got=%h exp=%h", f, res_a, e); end
      e = ref_conv(f, 16, 0, 1, 0);
      checks++; if (res_t0 !== e) begin errors++; $display("FAIL rand_trunc in=%h got=%h exp=%h", f, res_t0, e); end
      e = ref_conv(f, 16, 0, 1, 1);
      checks++; if (res_t1 !== e) begin errors++; $display("FAIL rand_away in=%h got=%h exp=%h", f, res_t1, e); end
      e = ref_conv(f, 16, 0, 1, 2);
      checks++; if (res_t2 !== e) begin errors++; $display("FAIL rand_even in=%h got=%h exp=%h", f, res_t2, e); end
      if (f[30:23] != 8'hFF) begin
        e = ref_conv(f, 8, 8, 0, 1);
        checks++; if (res_w !== e) begin errors++; $display("FAIL rand_wrap in=%h got=%h exp=%h", f, res_w, e); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] vec [10];
    logic [18:0] expq [$];
    logic [18:0] held, e;
    bit stalled, acc;
    int idx, got, cyc;
    for (int i = 0; i < 10; i++) begin
      vec[i] = rand_float();
      expq.push_back(ref_conv(vec[i], 8, 8, 1, 1));
    end
    idx = 0; got = 0; cyc = 0; stalled = 1'b0; held = '0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_float = vec[0]; out_ready = 1'($urandom_range(0, 1));
    while (got < 10 && cyc < 300) begin
      @(negedge clk);
      if (stalled) begin
        checks++;
        if ({if_a.out_valid, res_a} !== {1'b1, held}) begin
          errors++; $display("FAIL bp_stable got=%h exp=%h", {if_a.out_valid, res_a}, {1'b1, held});
        end
      end
      if (if_a.out_valid && out_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL bp_extra got=%h exp=none", res_a);
        end else begin
          e = expq.pop_front();
          if (res_a !== e) begin errors++; $display("FAIL bp_data idx=%0d got=%h exp=%h", got, res_a, e); end
        end
        got++;
      end
      stalled = if_a.out_valid && !out_ready;
      held    = res_a;
      acc     = in_valid && if_a.in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      if (idx < 10) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_float = vec[idx];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      cyc++;
    end
    checks++; if (got != 10) begin errors++; $display("FAIL bp_count got=%0d exp=10", got); end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got=%b exp=0", if_a.out_valid); end
    end
  endtask

  task automatic test_counters();
    int lat;
    do_reset();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_float = 32'h43000000;
    repeat (20) @(posedge clk);
    #1 in_float = 32'hFF800000;
    repeat (3) @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    checks++; if (cu_a !== 4'hF) begin errors++; $display("FAIL cnt_up_sat got=%0d exp=15", cu_a); end
    checks++; if (cd_a !== 4'd3) begin errors++; $display("FAIL cnt_down got=%0d exp=3", cd_a); end
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_float = 32'h43000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if ({if_a.out_valid, if_a.out_upflow} !== 2'b11) begin errors++; $display("FAIL cnt_stall_hold got=%b exp=11", {if_a.out_valid, if_a.out_upflow}); end
    @(posedge clk); #1;
    cnt_clr = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    checks++; if ({cu_a, cd_a} !== 8'h00) begin errors++; $display("FAIL cnt_clr_prio got=%h exp=00", {cu_a, cd_a}); end
    convert(32'h43000000, lat);
    @(negedge clk);
    checks++; if (cu_a !== 4'd1) begin errors++; $display("FAIL cnt_after_clr got=%0d exp=1", cu_a); end
  endtask

  task automatic test_reset_midstream();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_float = 32'h43000000;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%b exp=0", if_a.out_valid); end
    checks++; if ({cu_a, cd_a} !== 8'h00) begin errors++; $display("FAIL rst_mid_counters got=%h exp=00", {cu_a, cd_a}); end
    checks++; if (if_a.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%b exp=1", if_a.in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (if_a.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_flush got=%b exp=0", if_a.out_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_limits();
    test_random_model();
    test_backpressure();
    test_counters();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/pipe_float32_to_fixed_point.md
# pipe_float32_to_fixed_point

Streaming, pipelined IEEE-754 single-precision to signed fixed-point converter with valid/ready flow control, selectable rounding mode, correct two's-complement range limits, NaN detection and saturating overflow-event counters. It sits between float-producing stages, such as host data or float accumulators, and fixed-point datapaths. It is the throughput-oriented successor to the team's combinational converter: one conversion per cycle, 3-cycle latency.

## Interface
- WOI, 8, integer bits including sign; ≥1
- WOF, 8, fraction bits; ≥0; W = WOI+WOF, 2 ≤ W ≤ 64
- ROOF, 1, 1 = saturate on overflow; 0 = wrap (low W bits of two's-complement result)
- RMODE, 1, 0 = truncate magnitude (toward zero); 1 = round half away from zero; 2 = round half to even
- CNTW, 16, width of event counters
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input float valid
- in_ready  out  1  converter accepts input this cycle
- in_float  in  32  IEEE-754 single
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_fix  out  W  signed fixed-point result
- out_upflow  out  1  positive overflow (includes +inf)
- out_downflow  out  1  negative overflow (includes −inf)
- out_nan  out  1  input was NaN
- cnt_clr  in  1  synchronous clear of both counters
- cnt_upflow  out  CNTW  saturating count of upflow results delivered
- cnt_downflow  out  CNTW  saturating count of downflow results delivered

## Operation
- Classify: exp=255, mantissa≠0 → NaN: out_fix=0, out_nan=1, no up/downflow. exp=255, mantissa=0 → overflow of that sign. exp=0 (zero or denormal) → out_fix=0, no flags (denormals flushed).
- Normal: value = 1.m × 2^(exp−127). Magnitude aligned to WOF fraction bits. Guard = bit of weight 2^−(WOF+1); sticky = OR of all lower bits.
- Round on magnitude: RMODE0 adds 0; RMODE1 adds guard; RMODE2 adds guard & (sticky | lsb). Rounded magnitude M is kept wide enough that no carry is lost.
- Overflow is decided after rounding. Positive: M > 2^(W−1)−1. Negative: M > 2^(W−1). −2^(W−1) is representable and raises no flag.
- Saturating (ROOF=1): positive overflow gives 0x7F..F, negative gives 0x80..0. With ROOF=0, flags are still set and out_fix holds the wrapped two's-complement value.
- Non-overflow negative: out_fix = −M. −0.0 gives 0.
- Counters increment only on an output handshake (out_valid & out_ready) carrying the matching flag. They saturate at all-ones. cnt_clr has priority over increment in the same cycle.

## Timing
- Pipeline stages: S1 unpack/classify, S2 align/round, S3 sign/saturate/flags. Output registers are S3.
- Latency: an input accepted at cycle t produces out_valid at t+3 when not stalled.
- Global stall: en = !out_valid | out_ready, and in_ready = en. When en=0, all stages hold.
- Bubbles propagate as invalid stages; they are not compressed. Order is always preserved and no transfer is lost or duplicated.
- out_* fields are stable while out_valid=1 and out_ready=0.
- Reset: all stage valids clear, out_valid=0, out_fix=0, all flags 0, counters 0. rst mid-stream discards in-flight data. in_ready=1 in the cycle after reset.
- Full throughput: one result per cycle when in_valid=out_ready=1.

## Structure
- Package fxp_pkg: rmode_t enum (TRUNC, HALF_AWAY, HALF_EVEN), fclass_t enum (ZERO, NORM, INF, NAN), S1/S2 stage structs, W-derived max/min constants as functions of WOI/WOF.
- Sub-module comb_f32_mag_round: combinational align + guard/sticky + round. Used in S2 and unit-testable alone.
- Top level holds the pipeline registers, stall logic and counters.

## Test plan
- WOI=8, WOF=8, RMODE1: 0x3FC00000 (1.5) → 0x0180. 0xC2FF0000 (−127.5) → 0x8080. No flags.
- WOI=16, WOF=0: 2.5 → RMODE0 gives 0x0002, RMODE1 gives 0x0003, RMODE2 gives 0x0002. −2.5 → 0xFFFE / 0xFFFD / 0xFFFE. 3.5 with RMODE2 → 0x0004.
- WOI=8, WOF=8, ROOF=1: −128.0 (0xC3000000) → 0x8000, no flag. +128.0 → 0x7FFF, upflow. 0x42FFFFFF rounds (RMODE1) to 2^15 → 0x7FFF, upflow. −inf → 0x8000, downflow. 0x7FC00000 → 0x0000, nan. 0x00000001 → 0x0000, no flags.
- ROOF=0: +128.0 → 0x8000 with upflow=1.
- Backpressure: stream 10 random floats, toggle out_ready pseudo-randomly. Results must match the golden model in order, with no loss or duplication and stable data while stalled.
- Counters, CNTW=4: 20 upflow results → cnt_upflow=15 (saturated). cnt_clr coincident with an upflow handshake → 0. Assert rst mid-stream → out_valid=0 next cycle, counters 0.
